// File: rtl/cost_table_loader_pkg.sv
// cost_table_loader_pkg
// Constants, state encoding and the cost type shared by the loader and by
// the JAM permutation solver.
package cost_table_loader_pkg;

  localparam int N      = 8;          // workers = jobs
  localparam int COST_W = 7;          // bits per cost entry
  localparam int IDX_W  = 3;          // log2(N)
  localparam int LB_W   = 10;         // holds N*(2^COST_W-1) = 1016
  localparam int DEPTH  = N * N;      // table entries
  localparam int ADDR_W = 2 * IDX_W;  // {W,J} address

  typedef logic [COST_W-1:0] cost_t;

  // Loader FSM encoding
  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_FINAL = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  function automatic cost_t cost_min(input cost_t a, input cost_t b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/cost_table_loader_if.sv
// cost_table_loader_if
// Cost beat stream into the loader.
//   in_valid : producer has a beat on in_data
//   in_data  : cost beat, row-major order
//   in_ready : loader takes the beat this cycle
// Handshake: a beat transfers on a rising clock edge where in_valid and
// in_ready are both high. The producer holds in_data stable while in_valid
// is high and not yet accepted; in_ready may depend combinationally on
// in_valid-independent loader state only.
interface cost_table_loader_if;
  import cost_table_loader_pkg::*;

  logic  in_valid;
  cost_t in_data;
  logic  in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/cost_table_loader_cost_regfile.sv
// cost_regfile
// DEPTH x COST_W register file: one synchronous write port, one
// combinational read port, asynchronous active-low clear of every entry.
//   CLK, RST      : clock, async active-low clear
//   we/waddr/wdata: write port
//   raddr/rdata   : combinational read port
module cost_regfile
  import cost_table_loader_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  cost_t             wdata,
  input  logic [ADDR_W-1:0] raddr,
  output cost_t             rdata
);

  cost_t mem [DEPTH];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cost_table_loader.sv
// cost_table_loader
// Loads the NxN cost matrix from a valid/ready stream, serves Cost at the
// solver's (W,J) address, accumulates the sum of row minima while loading
// and pulses start when the table is complete.
//   CLK, RST    : clock, async active-low reset
//   s_in        : cost beat stream (slave side)
//   reload      : one-cycle request to discard the table and reload
//   W, J        : solver read address
//   Cost        : table[W*N+J], combinational
//   table_ready : table complete and stable
//   start       : one-cycle pulse on entering READY
//   LowerBound  : sum of row minima, valid while table_ready=1
//   state_dbg   : current FSM state
module cost_table_loader
  import cost_table_loader_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  cost_table_loader_if.slave   s_in,
  input  logic                 reload,
  input  logic [IDX_W-1:0]     W,
  input  logic [IDX_W-1:0]     J,
  output cost_t                Cost,
  output logic                 table_ready,
  output logic                 start,
  output logic [LB_W-1:0]      LowerBound,
  output logic [1:0]           state_dbg
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] wr_ptr;
  cost_t             row_min;
  logic [LB_W-1:0]   lb_acc;

  logic  accept;
  logic  col_first;
  logic  col_last;
  cost_t row_cand;

  // reload wins over a beat offered in the same cycle
  assign s_in.in_ready = (state == ST_LOAD) && !reload;
  assign accept        = s_in.in_valid && s_in.in_ready;

  assign col_first = (wr_ptr[IDX_W-1:0] == '0);
  assign col_last  = (wr_ptr[IDX_W-1:0] == IDX_W'(N - 1));

  // Column 0 starts a fresh row minimum, ignoring the all-ones parking value.
  assign row_cand = col_first ? s_in.in_data : cost_min(row_min, s_in.in_data);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= ST_LOAD;
      wr_ptr      <= '0;
      row_min     <= '1;
      lb_acc      <= '0;
      LowerBound  <= '0;
      table_ready <= 1'b0;
      start       <= 1'b0;
    end else if (reload) begin
      state       <= ST_LOAD;
      wr_ptr      <= '0;
      row_min     <= '1;
      lb_acc      <= '0;
      LowerBound  <= '0;
      table_ready <= 1'b0;
      start       <= 1'b0;
    end else begin
      start <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (col_last) begin
              lb_acc  <= lb_acc + LB_W'(row_cand);
              row_min <= '1;
            end else begin
              row_min <= row_cand;
            end
            if (wr_ptr == ADDR_W'(DEPTH - 1)) begin
              state <= ST_FINAL;
            end
          end
        end
        // lb_acc includes the last row only from this cycle on.
        ST_FINAL: begin
          LowerBound  <= lb_acc;
          table_ready <= 1'b1;
          start       <= 1'b1;
          state       <= ST_READY;
        end
        ST_READY: begin
          state <= ST_READY;
        end
        default: begin
          state <= ST_LOAD;
        end
      endcase
    end
  end

  cost_regfile u_regfile (
    .CLK   (CLK),
    .RST   (RST),
    .we    (accept),
    .waddr (wr_ptr),
    .wdata (s_in.in_data),
    .raddr ({W, J}),
    .rdata (Cost)
  );

  assign state_dbg = state;

endmodule

// File: doc/cost_table_loader.md
Name: cost_table_loader

Overview:
- Upstream feeder for the JAM permutation solver.
- Accepts the 8x8 worker/job cost matrix as a valid/ready stream and stores it in a 64-entry register file.
- Serves Cost combinationally at the solver's (W,J) address.
- Computes the per-row-minimum lower bound while loading, and pulses a start strobe so the solver can begin enumerating.

Parameters:
- N, 8, workers = jobs; table depth N*N.
- COST_W, 7, bits per cost entry.
- IDX_W, 3, bits of W/J index (log2 N).
- LB_W, 10, lower-bound accumulator width (N*(2^COST_W-1) = 1016 fits).

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  reset, asynchronous, active-low.
- in_valid  in  1  cost beat present.
- in_data  in  COST_W  cost beat, row-major order: entry (w,j) is beat w*N+j.
- in_ready  out  1  loader accepts a beat this cycle.
- reload  in  1  one-cycle request to discard the table and start a new load.
- W  in  IDX_W  worker index from solver.
- J  in  IDX_W  job index from solver.
- Cost  out  COST_W  table[W*N+J], combinational.
- table_ready  out  1  table complete and stable.
- start  out  1  one-cycle pulse on entering READY; drives solver release.
- LowerBound  out  LB_W  sum over rows of the row minimum; valid while table_ready=1.

Behaviour:
- States: LOAD, FINAL, READY. The reset state is LOAD.
- Reset values (asynchronous, RST=0):
  - state=LOAD, wr_ptr=0, all 64 entries=0.
  - row_min=all ones, lb_acc=0, LowerBound=0.
  - table_ready=0, start=0.
- in_ready = (state==LOAD) && !reload. This is combinational; it goes high in the first cycle after reset is released.
- Beat accepted when in_valid && in_ready:
  - table[wr_ptr] <= in_data; wr_ptr increments (6 bits).
  - row_min <= min(row_min, in_data); for column 0, row_min <= in_data.
  - For column N-1, lb_acc <= lb_acc + min(row_min, in_data), zero-extended to LB_W, and row_min is reset to all ones.
- in_valid low inserts a bubble: no change to any state.
- Accepting beat 63 at cycle t:
  - state=FINAL at t+1.
  - LowerBound <= lb_acc at t+1.
  - state=READY with table_ready=1 and start=1 at t+2.
  - start=0 from t+3.
- READY:
  - in_ready=0; beats are ignored.
  - table, LowerBound and table_ready stay static until reload.
- reload:
  - Allowed in any state; it has priority over an accepted beat in the same cycle, so that beat is not accepted (in_ready=0).
  - Next cycle: state=LOAD, wr_ptr=0, row_min=all ones, lb_acc=0, table_ready=0, LowerBound=0.
  - Table contents are not cleared; they are overwritten as beats arrive.
  - reload during FINAL cancels READY entry, so no start pulse is issued.
- Cost is always table[{W,J}] regardless of state. The solver must only use it while table_ready=1.
- Reset asserted mid-load returns immediately to the reset values. Partial data is discarded, i.e. the entries are zeroed.
- No overflow is possible: LB_W is sized for the worst case.

Decomposition:
- Shared package holds:
  - constants N, COST_W, IDX_W, LB_W;
  - state encoding LOAD/FINAL/READY;
  - a cost_t typedef (COST_W bits).
- The solver reuses the same constants.
- One natural sub-module: cost_regfile. It is a 64 x COST_W array with a write port (we, waddr, wdata), an asynchronous active-low clear, and a combinational read port (raddr, rdata).
- The loader FSM, row-min and accumulator logic stay in the top.

Test Plan:
- Reset release, 64 back-to-back beats with in_data = 8w+j:
  - table_ready=1 and start pulses exactly 2 cycles after the last beat.
  - LowerBound = 224.
  - W=3,J=5 gives Cost=29; W=7,J=7 gives Cost=63.
- Same data with in_valid low on every other cycle:
  - identical table and LowerBound=224;
  - beat count exactly 64, with no duplicates or drops.
- All beats 127 → LowerBound=1016 with no wrap. Then rows w having in_data=100-w everywhere except (w,w)=w → LowerBound=28.
- reload after 10 beats, then 64 beats with in_data=5:
  - LowerBound=40; every Cost=5; start pulses once.
  - reload together with in_valid in the same cycle: that beat is not accepted.
- In READY, drive in_valid=1 with random data → in_ready=0 and the table is unchanged. A subsequent reload drops table_ready the next cycle.
- RST low for one cycle after 30 beats:
  - all outputs return to reset values; Cost=0 for every (W,J);
  - a following full load completes normally.
